// File: rtl/fft_common_pkg.sv
// Shared MultimodeFFT datapath definitions.
//   WIDTH    - default two's-complement sample width
//   SAT_MAX  - largest positive value at WIDTH
//   SAT_MIN  - most negative value at WIDTH
//   cplx_t   - packed complex sample (re, im)
package fft_common_pkg;

    localparam int unsigned WIDTH = 16;

    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef struct packed {
        logic [WIDTH-1:0] re;
        logic [WIDTH-1:0] im;
    } cplx_t;

endpackage

// File: rtl/complex_adder.sv
// Combinational saturating complex adder.
//   a_re, a_im, b_re, b_im - two's-complement operands
//   sum_re, sum_im         - component sums, each clamped to the WIDTH range
//   ovf                    - set when either component saturated
module complex_adder #(
    parameter int unsigned WIDTH = fft_common_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] a_re,
    input  logic [WIDTH-1:0] a_im,
    input  logic [WIDTH-1:0] b_re,
    input  logic [WIDTH-1:0] b_im,
    output logic [WIDTH-1:0] sum_re,
    output logic [WIDTH-1:0] sum_im,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MaxVal = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH:0] wide_re;
    logic [WIDTH:0] wide_im;
    logic           ovf_re;
    logic           ovf_im;

    always_comb begin
        wide_re = {a_re[WIDTH-1], a_re} + {b_re[WIDTH-1], b_re};
        wide_im = {a_im[WIDTH-1], a_im} + {b_im[WIDTH-1], b_im};
        // The extra sign bit disagrees with the WIDTH-bit sign only on overflow.
        ovf_re  = wide_re[WIDTH] ^ wide_re[WIDTH-1];
        ovf_im  = wide_im[WIDTH] ^ wide_im[WIDTH-1];
        sum_re  = ovf_re ? (wide_re[WIDTH] ? MinVal : MaxVal) : wide_re[WIDTH-1:0];
        sum_im  = ovf_im ? (wide_im[WIDTH] ? MinVal : MaxVal) : wide_im[WIDTH-1:0];
        ovf     = ovf_re | ovf_im;
    end

endmodule

// File: rtl/cadd_rr_arbiter.sv
// Round-robin arbiter that time-shares one saturating complex adder.
//   clk, rst_n            - clock, async active-low reset
//   req_valid/req_ready   - per-requester handshake (ready is one-hot or zero)
//   req_a_*/req_b_*       - packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_tag               - packed opaque tags
//   out_valid/out_ready   - result handshake
//   out_re/out_im/out_ovf - registered saturated sum and its overflow flag
//   out_src/out_tag       - granted requester index and its tag
//   clr_status            - synchronous clear of ovf_sticky and sat_count
//   ovf_sticky, sat_count - overflow status for the mode controller
module cadd_rr_arbiter #(
    parameter int unsigned WIDTH   = fft_common_pkg::WIDTH,
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TAG_W   = 4,
    localparam int unsigned SRC_W  = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a_re,
    input  logic [NUM_REQ*WIDTH-1:0] req_a_im,
    input  logic [NUM_REQ*WIDTH-1:0] req_b_re,
    input  logic [NUM_REQ*WIDTH-1:0] req_b_im,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_re,
    output logic [WIDTH-1:0]         out_im,
    output logic                     out_ovf,
    output logic [SRC_W-1:0]         out_src,
    output logic [TAG_W-1:0]         out_tag,
    input  logic                     clr_status,
    output logic                     ovf_sticky,
    output logic [15:0]              sat_count
);

    // One-hot grant for the first valid requester at or after ptr, wrapping.
    function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                   input logic [SRC_W-1:0]   ptr);
        logic [NUM_REQ-1:0] grant;
        logic               found;
        int unsigned        idx;
        grant = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && valid[idx[SRC_W-1:0]]) begin
                grant[idx[SRC_W-1:0]] = 1'b1;
                found                 = 1'b1;
            end
        end
        return grant;
    endfunction

    logic               out_valid_q;
    logic [WIDTH-1:0]   out_re_q;
    logic [WIDTH-1:0]   out_im_q;
    logic               out_ovf_q;
    logic [SRC_W-1:0]   out_src_q;
    logic [TAG_W-1:0]   out_tag_q;
    logic [SRC_W-1:0]   rr_ptr_q;
    logic               ovf_sticky_q;
    logic [15:0]        sat_count_q;

    logic               slot_free;
    logic [NUM_REQ-1:0] grant;
    logic               accept;
    logic [SRC_W-1:0]   gnt_idx;
    logic [SRC_W-1:0]   rr_ptr_d;
    logic [WIDTH-1:0]   sel_a_re;
    logic [WIDTH-1:0]   sel_a_im;
    logic [WIDTH-1:0]   sel_b_re;
    logic [WIDTH-1:0]   sel_b_im;
    logic [TAG_W-1:0]   sel_tag;
    logic [WIDTH-1:0]   sum_re;
    logic [WIDTH-1:0]   sum_im;
    logic               sum_ovf;
    logic               sat_event;
    logic               ovf_sticky_d;
    logic [15:0]        sat_count_d;

    assign slot_free = !out_valid_q || out_ready;
    // Gating with rst_n keeps ready low during reset even though slot_free is high then.
    assign grant     = (slot_free && rst_n) ? rr_pick(req_valid, rr_ptr_q) : '0;
    assign accept    = |grant;
    assign req_ready = grant;

    // Encode the grant and mux the granted operands into the shared adder.
    always_comb begin
        gnt_idx  = '0;
        sel_a_re = '0;
        sel_a_im = '0;
        sel_b_re = '0;
        sel_b_im = '0;
        sel_tag  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                gnt_idx  = SRC_W'(i);
                sel_a_re = req_a_re[i*WIDTH +: WIDTH];
                sel_a_im = req_a_im[i*WIDTH +: WIDTH];
                sel_b_re = req_b_re[i*WIDTH +: WIDTH];
                sel_b_im = req_b_im[i*WIDTH +: WIDTH];
                sel_tag  = req_tag[i*TAG_W +: TAG_W];
            end
        end
    end

    complex_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a_re   (sel_a_re),
        .a_im   (sel_a_im),
        .b_re   (sel_b_re),
        .b_im   (sel_b_im),
        .sum_re (sum_re),
        .sum_im (sum_im),
        .ovf    (sum_ovf)
    );

    assign rr_ptr_d  = (gnt_idx == SRC_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    assign sat_event = accept && sum_ovf;

    // A clear in the same cycle as a saturating accept still records that event.
    always_comb begin
        ovf_sticky_d = ovf_sticky_q | sat_event;
        sat_count_d  = sat_count_q;
        if (clr_status) begin
            ovf_sticky_d = sat_event;
            sat_count_d  = {15'd0, sat_event};
        end else if (sat_event && (sat_count_q != 16'hFFFF)) begin
            sat_count_d = sat_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            out_ovf_q   <= 1'b0;
            out_src_q   <= '0;
            out_tag_q   <= '0;
            rr_ptr_q    <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_re_q    <= sum_re;
            out_im_q    <= sum_im;
            out_ovf_q   <= sum_ovf;
            out_src_q   <= gnt_idx;
            out_tag_q   <= sel_tag;
            rr_ptr_q    <= rr_ptr_d;
        end else if (slot_free) begin
            out_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky_q <= 1'b0;
            sat_count_q  <= '0;
        end else begin
            ovf_sticky_q <= ovf_sticky_d;
            sat_count_q  <= sat_count_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_re     = out_re_q;
    assign out_im     = out_im_q;
    assign out_ovf    = out_ovf_q;
    assign out_src    = out_src_q;
    assign out_tag    = out_tag_q;
    assign ovf_sticky = ovf_sticky_q;
    assign sat_count  = sat_count_q;

endmodule

// File: tb/tb_cadd_rr_arbiter.sv
// Directed bench for cadd_rr_arbiter with WIDTH=16, NUM_REQ=4, TAG_W=4.
module tb_cadd_rr_arbiter;
    import fft_common_pkg::*;

    localparam int unsigned W  = 16;
    localparam int unsigned N  = 4;
    localparam int unsigned TW = 4;
    localparam int unsigned SW = 2;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_a_re;
    logic [N*W-1:0]  req_a_im;
    logic [N*W-1:0]  req_b_re;
    logic [N*W-1:0]  req_b_im;
    logic [N*TW-1:0] req_tag;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_re;
    logic [W-1:0]    out_im;
    logic            out_ovf;
    logic [SW-1:0]   out_src;
    logic [TW-1:0]   out_tag;
    logic            clr_status;
    logic            ovf_sticky;
    logic [15:0]     sat_count;

    int vectors;
    int miscompares;

    cadd_rr_arbiter #(
        .WIDTH   (W),
        .NUM_REQ (N),
        .TAG_W   (TW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a_re   (req_a_re),
        .req_a_im   (req_a_im),
        .req_b_re   (req_b_re),
        .req_b_im   (req_b_im),
        .req_tag    (req_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_re     (out_re),
        .out_im     (out_im),
        .out_ovf    (out_ovf),
        .out_src    (out_src),
        .out_tag    (out_tag),
        .clr_status (clr_status),
        .ovf_sticky (ovf_sticky),
        .sat_count  (sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [15:0] are, input logic [15:0] aim,
                           input logic [15:0] bre, input logic [15:0] bim,
                           input logic [3:0] tg);
        req_a_re[i*W +: W]  = are;
        req_a_im[i*W +: W]  = aim;
        req_b_re[i*W +: W]  = bre;
        req_b_im[i*W +: W]  = bim;
        req_tag[i*TW +: TW] = tg;
    endtask

    initial begin
        int exp_src;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        req_valid   = '0;
        req_a_re    = '0;
        req_a_im    = '0;
        req_b_re    = '0;
        req_b_im    = '0;
        req_tag     = '0;
        out_ready   = 1'b1;
        clr_status  = 1'b0;

        // Reset state, with all requesters valid.
        req_valid = 4'hF;
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_re", 32'(out_re), 32'd0);
        check("rst_out_im", 32'(out_im), 32'd0);
        check("rst_out_ovf", 32'(out_ovf), 32'd0);
        check("rst_out_src", 32'(out_src), 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        check("rst_sticky", 32'(ovf_sticky), 32'd0);
        check("rst_sat_count", 32'(sat_count), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single requester 2.
        set_req(2, 16'h0100, 16'hFF00, 16'h0020, 16'h0010, 4'd5);
        req_valid = 4'b0100;
        #1;
        check("single_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_re", 32'(out_re), 32'h0120);
        check("single_im", 32'(out_im), 32'hFF10);
        check("single_src", 32'(out_src), 32'd2);
        check("single_tag", 32'(out_tag), 32'd5);
        check("single_ovf", 32'(out_ovf), 32'd0);

        // All valid: pointer is 3, so grants go 3,0,1,2,3,0,1,2,3.
        for (int i = 0; i < 4; i++) begin
            set_req(i, 16'(i), 16'h0000, 16'h0010, 16'h0020, 4'(i + 8));
        end
        req_valid = 4'hF;
        for (int k = 0; k < 9; k++) begin
            exp_src = (3 + k) % 4;
            #1;
            check("rr_ready", 32'(req_ready), 32'(1 << exp_src));
            tick();
            check("rr_valid", 32'(out_valid), 32'd1);
            check("rr_src", 32'(out_src), 32'(exp_src));
            check("rr_tag", 32'(out_tag), 32'(exp_src + 8));
            check("rr_re", 32'(out_re), 32'(16 + exp_src));
            check("rr_im", 32'(out_im), 32'h20);
        end
        req_valid = '0;
        tick();
        check("idle_valid", 32'(out_valid), 32'd0);
        check("idle_src_hold", 32'(out_src), 32'd3);
        check("idle_sat_count", 32'(sat_count), 32'd0);

        // Saturation on requester 1 (pointer now 0).
        set_req(1, 16'h7000, 16'h8000, 16'h2000, 16'hFFFF, 4'd3);
        req_valid = 4'b0010;
        #1;
        check("sat_ready", 32'(req_ready), 32'h2);
        tick();
        check("sat_re", 32'(out_re), 32'(SAT_MAX));
        check("sat_im", 32'(out_im), 32'(SAT_MIN));
        check("sat_ovf", 32'(out_ovf), 32'd1);
        check("sat_sticky", 32'(ovf_sticky), 32'd1);
        check("sat_count1", 32'(sat_count), 32'd1);
        check("sat_src", 32'(out_src), 32'd1);
        check("sat_tag", 32'(out_tag), 32'd3);

        // Backpressure for 3 cycles; pointer is 2.
        out_ready = 1'b0;
        req_valid = 4'hF;
        #1;
        check("bp_ready0", 32'(req_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_re", 32'(out_re), 32'h7FFF);
            check("bp_im", 32'(out_im), 32'h8000);
            check("bp_src", 32'(out_src), 32'd1);
            check("bp_ready", 32'(req_ready), 32'd0);
            check("bp_sat_count", 32'(sat_count), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(req_ready), 32'h4);
        tick();
        check("bp_release_src", 32'(out_src), 32'd2);
        check("bp_release_re", 32'(out_re), 32'h12);
        check("bp_release_ovf", 32'(out_ovf), 32'd0);
        check("bp_release_cnt", 32'(sat_count), 32'd1);

        // Six more saturating accepts bring the count to 7.
        req_valid = 4'b0010;
        repeat (6) tick();
        check("cnt7", 32'(sat_count), 32'd7);
        clr_status = 1'b1;
        tick();
        check("clr_hit_cnt", 32'(sat_count), 32'd1);
        check("clr_hit_sticky", 32'(ovf_sticky), 32'd1);
        req_valid = '0;
        tick();
        check("clr_cnt", 32'(sat_count), 32'd0);
        check("clr_sticky", 32'(ovf_sticky), 32'd0);
        clr_status = 1'b0;

        // Counter holds at 0xFFFF.
        req_valid = 4'b0010;
        repeat (65540) @(posedge clk);
        #1;
        check("cnt_sat", 32'(sat_count), 32'hFFFF);
        check("cnt_sat_sticky", 32'(ovf_sticky), 32'd1);
        req_valid  = '0;
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        check("cnt_sat_clr", 32'(sat_count), 32'd0);

        // Pointer is 2: accept requester 2, leaving pointer 3 and a pending result.
        req_valid = 4'b0100;
        tick();
        out_ready = 1'b0;
        req_valid = 4'b1001;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        check("pre_rst_src", 32'(out_src), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_re", 32'(out_re), 32'd0);
        check("mid_rst_im", 32'(out_im), 32'd0);
        check("mid_rst_src", 32'(out_src), 32'd0);
        check("mid_rst_tag", 32'(out_tag), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("post_rst_ready", 32'(req_ready), 32'h1);
        tick();
        check("post_rst_src0", 32'(out_src), 32'd0);
        check("post_rst_valid", 32'(out_valid), 32'd1);
        tick();
        check("post_rst_src3", 32'(out_src), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
